hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max memory-wait cycles before forced release (range 2..255).
REQ-002 SHALL have clk  input  1  pipeline clock, rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have Rs1D, Rs2D  input  5 each  decode-stage source registers.
REQ-005 SHALL have Rs1E, Rs2E, RdE  input  5 each  execute-stage source/destination registers.
REQ-006 SHALL have RdM, RdW  input  5 each  memory/writeback-stage destination registers.
REQ-007 SHALL have RegWriteM, RegWriteW  input  1 each  stage writes register file.
REQ-008 SHALL have LoadE  input  1  execute-stage instruction is a load.
REQ-009 SHALL have PCSrcE  input  1  branch/jump taken, resolved in execute.
REQ-010 SHALL have MemReqM, MemReadyM  input  1 each  data-memory access pending / memory completes this cycle.
REQ-011 SHALL have ForwardAE, ForwardBE  output  2 each  operand select: 00 regfile, 01 writeback result, 10 memory-stage ALU result.
REQ-012 SHALL have StallF, StallD, StallE, StallM  output  1 each  hold stage register.
REQ-013 SHALL have FlushD, FlushE, FlushW  output  1 each  clear stage register to a bubble.
REQ-014 SHALL have MemErr  output  1  sticky memory-timeout flag.

Function
REQ-015 ForwardAE SHALL be 10 if RegWriteM, RdM!=0, RdM==Rs1E; else 01 if RegWriteW, RdW!=0, RdW==Rs1E; else 00 (memory stage wins); ForwardBE identical using Rs2E.
REQ-016 lwStall SHALL be LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D); x0 never causes a stall.
REQ-017 FSM SHALL have states RUN and MEM_WAIT, held in registers.
REQ-018 RUN->MEM_WAIT on clock edge when MemReqM=1 and MemReadyM=0; MEM_WAIT->RUN on edge when MemReadyM=1 or wait counter reaches MEM_TIMEOUT-1.
REQ-019 memWait SHALL be (MemReqM & !MemReadyM) in any state, unless in MEM_WAIT with counter at MEM_TIMEOUT-1 (forced release cycle).
REQ-020 While memWait=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; lwStall and PCSrcE ignored.
REQ-021 Else if PCSrcE=1: FlushD=FlushE=1, all stalls 0 (branch wins over lwStall if both asserted).
REQ-022 Else if lwStall: StallF=StallD=1, FlushE=1, others 0.
REQ-023 Else all stall/flush outputs 0.
REQ-024 Stall/flush outputs SHALL be combinational from inputs and current state (zero-cycle latency); forwarding combinational in all states.
REQ-025 Wait counter (8-bit) SHALL clear in RUN and on exit, increment each cycle in MEM_WAIT.
REQ-026 MemErr SHALL set on the forced-release edge and hold until reset; no other clear.
REQ-027 MemReadyM=1 on the same cycle as MemReqM=1 SHALL produce no stall and no state change.

Reset
REQ-028 reset low SHALL asynchronously force state RUN, wait counter 0, MemErr 0, performance counters 0.
REQ-029 While reset low, all stall/flush outputs SHALL be 0 and ForwardAE/ForwardBE 00.
REQ-030 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after release FSM starts in RUN.

Configuration
REQ-031 Macro HAZARD_PERF_EN defined SHALL add outputs StallCount and FlushCount (32 bits each): StallCount +1 per cycle with StallF=1, FlushCount +1 per cycle with FlushE=1, both saturating at 0xFFFFFFFF.
REQ-032 HAZARD_PERF_EN undefined SHALL omit both ports and counters; all other behaviour unchanged.

Verification
REQ-033 RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00.
REQ-034 LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for that cycle; RdE=0 repeat -> no stall.
REQ-035 PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-036 MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> all four stalls and FlushW high 3 cycles, low on ready cycle, state RUN afterwards, MemErr 0.
REQ-037 MEM_TIMEOUT=4, MemReadyM held 0 -> stalls high 4 cycles (RUN cycle + 3 MEM_WAIT cycles), released on 5th cycle (counter 3), MemErr=1 after that edge and stays 1 until reset low.
REQ-038 With HAZARD_PERF_EN: 10 load-use stalls -> StallCount=10; reset low mid-MEM_WAIT -> counters 0, state RUN, outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and a
// memory-wait FSM with timeout. Define HAZARD_PERF_EN to add stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       LoadE,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  localparam logic [7:0] LIMIT    = 8'(MEM_TIMEOUT - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;
  logic       at_limit, forced, mem_wait, lw_stall;

  // Memory stage result is younger than writeback, so it takes priority.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rdm, input logic ww,
                                         input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign ForwardAE = reset ? fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW) : 2'b00;
  assign ForwardBE = reset ? fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW) : 2'b00;

  assign at_limit = (state_q == MEM_WAIT) && (cnt_q == LIMIT);
  assign forced   = at_limit && !MemReadyM;
  assign mem_wait = MemReqM && !MemReadyM && !at_limit;
  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign MemErr   = err_q;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      if (mem_wait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (MemReadyM || at_limit) state_d = RUN;
        else                       cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (forced) err_q <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (StallF && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (FlushE && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver predicts each cycle's outputs from
// a request-level model; a monitor on the falling edge checks the DUT against them.
module tb_hazard_ctrl;
  localparam int TO = 4;

  typedef struct {
    logic [1:0]  fa, fb;
    logic        sf, sd, se, sm, fd, fe, fw, err;
    logic [31:0] sc, fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic       RegWriteM = 0, RegWriteW = 0, LoadE = 0, PCSrcE = 0, MemReqM = 0, MemReadyM = 0;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [31:0] sc_o, fc_o;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr)
`ifdef HAZARD_PERF_EN
    , .StallCount(sc_o), .FlushCount(fc_o)
`endif
  );

`ifndef HAZARD_PERF_EN
  assign sc_o = '0;
  assign fc_o = '0;
`endif

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  // Model state: consecutive unanswered memory cycles, sticky error, event tallies.
  int   pend = 0;
  bit   err_m = 0;
  int unsigned sc_m = 0, fc_m = 0;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs)      return 2'b10;
    else if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Predict this cycle's outputs, advance the model, move to posedge+1.
  task automatic step();
    exp_t e;
    bit lw, blocked, forced, mw;
    e = '{fa: 2'b00, fb: 2'b00, sf: 0, sd: 0, se: 0, sm: 0, fd: 0, fe: 0, fw: 0,
          err: 0, sc: 0, fc: 0};
    if (!reset) begin
      pend = 0; err_m = 0; sc_m = 0; fc_m = 0;
      exp_q.push_back(e);
    end else begin
      e.fa = fwd(Rs1E);
      e.fb = fwd(Rs2E);
      lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      blocked = MemReqM && !MemReadyM;
      forced = blocked && pend == TO;
      mw = blocked && !forced;
      if (mw) begin
        e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
      end else if (PCSrcE) begin
        e.fd = 1; e.fe = 1;
      end else if (lw) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end
      e.err = err_m; e.sc = sc_m; e.fc = fc_m;
      exp_q.push_back(e);
      pend = mw ? pend + 1 : 0;
      if (forced) err_m = 1;
      if (e.sf) sc_m++;
      if (e.fe) fc_m++;
    end
    @(posedge clk); #1;
  endtask

  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
        chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
        chk("StallF", 32'(StallF), 32'(e.sf));
        chk("StallD", 32'(StallD), 32'(e.sd));
        chk("StallE", 32'(StallE), 32'(e.se));
        chk("StallM", 32'(StallM), 32'(e.sm));
        chk("FlushD", 32'(FlushD), 32'(e.fd));
        chk("FlushE", 32'(FlushE), 32'(e.fe));
        chk("FlushW", 32'(FlushW), 32'(e.fw));
        chk("MemErr", 32'(MemErr), 32'(e.err));
`ifdef HAZARD_PERF_EN
        chk("StallCount", sc_o, e.sc);
        chk("FlushCount", fc_o, e.fc);
`endif
      end
    end
  end

  initial begin : driver
    @(posedge clk); #1;
    // Outputs held quiet under reset even with hazards present on the inputs.
    RegWriteM = 1; RdM = 5; Rs1E = 5; LoadE = 1; RdE = 7; Rs2D = 7; MemReqM = 1;
    step(); step();
    clr(); reset = 1'b1;
    step();
    // Both stages target x5; memory stage wins.
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
    step();
    RegWriteM = 0; Rs2E = 5; step();
    clr(); RegWriteM = 1; RdM = 0; Rs1E = 0; step();
    // Load-use, then x0 destination.
    clr(); LoadE = 1; RdE = 7; Rs2D = 7; step();
    RdE = 0; Rs2D = 0; step();
    // Branch beats load-use.
    clr(); LoadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1; step();
    // Memory wait of 3 cycles then ready.
    clr(); MemReqM = 1; PCSrcE = 1; LoadE = 1; RdE = 3; Rs1D = 3;
    repeat (3) step();
    MemReadyM = 1; step();
    clr(); step();
    // Same-cycle ready: no stall.
    MemReqM = 1; MemReadyM = 1; step();
    // Timeout: 4 stalled cycles, forced release on the 5th, sticky error.
    clr(); MemReqM = 1;
    repeat (TO + 1) step();
    clr(); repeat (2) step();
    // Ten load-use stalls from a clean reset.
    reset = 1'b0; step(); reset = 1'b1;
    clr(); LoadE = 1; RdE = 9; Rs1D = 9;
    repeat (10) step();
    clr(); step();
    // Reset mid-wait abandons it; afterwards a new wait starts from RUN.
    MemReqM = 1; repeat (2) step();
    reset = 1'b0; repeat (2) step();
    reset = 1'b1; clr(); step();
    MemReqM = 1; repeat (TO + 1) step();
    clr(); step();
    // Randomized traffic; memory requests stay up until answered or released.
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE = 5'($urandom_range(0, 7)); RdM = 5'($urandom_range(0, 7));
      RdW = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      LoadE = ($urandom_range(0, 3) == 0);
      PCSrcE = ($urandom_range(0, 6) == 0);
      if (pend > 0) begin
        MemReqM = 1; MemReadyM = ($urandom_range(0, 3) == 0);
      end else begin
        MemReqM = ($urandom_range(0, 3) == 0); MemReadyM = 1'($urandom_range(0, 1));
      end
      if (i == 200) reset = 1'b0;
      if (i == 202) reset = 1'b1;
      step();
    end
    clr(); step();
    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
